// File: rtl/dcache_mem_responder_pkg.sv
// Shared definitions for the direct-mapped write-through data cache:
// FSM encoding and address-field width helpers.
package dcache_mem_responder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        WDONE = 2'd3
    } dcacheState_e;

    localparam int OFF_W = 3;

    function automatic int wselWidth(input int wordsPerLine);
        return $clog2(wordsPerLine);
    endfunction

    function automatic int idxWidth(input int lines);
        return $clog2(lines);
    endfunction

    function automatic int tagWidth(input int addrW, input int lines, input int wordsPerLine);
        return addrW - OFF_W - $clog2(lines) - $clog2(wordsPerLine);
    endfunction

endpackage

// File: rtl/dcache_line_store.sv
// Tag, valid and data arrays for the data cache: combinational read port,
// one posedge write port (single word and/or tag+valid).
module dcache_line_store
    import dcache_mem_responder_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int TAG_W          = 55,
    localparam int IDX_W         = idxWidth(LINES),
    localparam int WSEL_W        = wselWidth(WORDS_PER_LINE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  rdIndex,
    input  logic [WSEL_W-1:0] rdWordSel,
    output logic              rdValid,
    output logic [TAG_W-1:0]  rdTag,
    output logic [63:0]       rdData,
    input  logic              wrWordEn,
    input  logic              wrTagEn,
    input  logic [IDX_W-1:0]  wrIndex,
    input  logic [WSEL_W-1:0] wrWordSel,
    input  logic [63:0]       wrData,
    input  logic [TAG_W-1:0]  wrTag
);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];
    logic [63:0]      words [LINES][WORDS_PER_LINE];

    // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (wrTagEn) begin
            valid[wrIndex] <= 1'b1;
        end
    end

    // NOTE: tag/data arrays carry no reset; contents are don't-care until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wrWordEn) begin
            words[wrIndex][wrWordSel] <= wrData;
        end
        if (wrTagEn) begin
            tags[wrIndex] <= wrTag;
        end
    end

    assign rdValid = valid[rdIndex];
    assign rdTag   = tags[rdIndex];
    assign rdData  = words[rdIndex][rdWordSel];

endmodule

// File: rtl/dcache_mem_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache for the MEM stage;
// drives the MEM/WB hit gate and runs line-fill / write-through memory handshakes.
module dcache_mem_responder
    import dcache_mem_responder_pkg::*;
#(
    parameter int LINES          = 16,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       writeData,
    output logic              hit,
    output logic [63:0]       readData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [63:0]       mem_rdata
);

    localparam int WSEL_W = wselWidth(WORDS_PER_LINE);
    localparam int IDX_W  = idxWidth(LINES);
    localparam int TAG_W  = tagWidth(ADDR_W, LINES, WORDS_PER_LINE);
    localparam logic [WSEL_W-1:0] LAST_BEAT = WSEL_W'(WORDS_PER_LINE - 1);

    dcacheState_e state, stateNext;

    logic              memReqNext, memWeNext;
    logic [ADDR_W-1:0] memAddrNext;
    logic [63:0]       memWdataNext;
    logic [WSEL_W-1:0] fillCnt, fillCntNext;

    logic [ADDR_W-1:0] lookupAddr;
    logic [TAG_W-1:0]  lookupTag;
    logic [IDX_W-1:0]  lookupIdx;
    logic [WSEL_W-1:0] lookupWsel;
    logic              rdValid, lineHit;
    logic [TAG_W-1:0]  rdTag;
    logic [63:0]       rdData;
    logic              wrWordEn, wrTagEn;
    logic [WSEL_W-1:0] wrWordSel;
    logic [63:0]       wrData;
    logic              unusedOffsetBits;

    // Outside IDLE the cache works on the latched memory address, not the pipeline's.
    assign lookupAddr       = (state == IDLE) ? address : mem_addr;
    assign lookupTag        = lookupAddr[ADDR_W-1 -: TAG_W];
    assign lookupIdx        = lookupAddr[OFF_W+WSEL_W +: IDX_W];
    assign lookupWsel       = lookupAddr[OFF_W +: WSEL_W];
    assign lineHit          = rdValid && (rdTag == lookupTag);
    assign unusedOffsetBits = ^lookupAddr[OFF_W-1:0];

    dcache_line_store #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WORDS_PER_LINE),
        .TAG_W          (TAG_W)
    ) u_lineStore (
        .clk       (clk),
        .rst_n     (rst_n),
        .rdIndex   (lookupIdx),
        .rdWordSel (lookupWsel),
        .rdValid   (rdValid),
        .rdTag     (rdTag),
        .rdData    (rdData),
        .wrWordEn  (wrWordEn),
        .wrTagEn   (wrTagEn),
        .wrIndex   (lookupIdx),
        .wrWordSel (wrWordSel),
        .wrData    (wrData),
        .wrTag     (lookupTag)
    );

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        stateNext    = state;
        memReqNext   = mem_req;
        memWeNext    = mem_we;
        memAddrNext  = mem_addr;
        memWdataNext = mem_wdata;
        fillCntNext  = fillCnt;
        wrWordEn     = 1'b0;
        wrTagEn      = 1'b0;
        wrWordSel    = lookupWsel;
        wrData       = mem_wdata;
        hit          = 1'b0;
        readData     = '0;

        case (state)
            IDLE: begin
                hit = 1'b1;
                if (MemWrite) begin
                    hit          = 1'b0;
                    stateNext    = WRITE;
                    memReqNext   = 1'b1;
                    memWeNext    = 1'b1;
                    memAddrNext  = {address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                    memWdataNext = writeData;
                end else if (MemRead) begin
                    if (lineHit) begin
                        readData = rdData;
                    end else begin
                        hit         = 1'b0;
                        stateNext   = FILL;
                        memReqNext  = 1'b1;
                        memWeNext   = 1'b0;
                        memAddrNext = {address[ADDR_W-1:OFF_W+WSEL_W], {(OFF_W+WSEL_W){1'b0}}};
                        fillCntNext = '0;
                    end
                end
            end
            FILL: begin
                if (mem_ready) begin
                    wrWordEn    = 1'b1;
                    wrWordSel   = fillCnt;
                    wrData      = mem_rdata;
                    fillCntNext = fillCnt + 1'b1;
                    memAddrNext = mem_addr + ADDR_W'(8);
                    if (fillCnt == LAST_BEAT) begin
                        wrTagEn    = 1'b1;
                        memReqNext = 1'b0;
                        stateNext  = IDLE;
                    end
                end
            end
            WRITE: begin
                if (mem_ready) begin
                    wrWordEn   = lineHit;
                    memReqNext = 1'b0;
                    stateNext  = WDONE;
                end
            end
            WDONE: begin
                // Releases the pipeline once; the still-held store is not re-examined.
                hit       = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            fillCnt   <= '0;
        end else begin
            state     <= stateNext;
            mem_req   <= memReqNext;
            mem_we    <= memWeNext;
            mem_addr  <= memAddrNext;
            mem_wdata <= memWdataNext;
            fillCnt   <= fillCntNext;
        end
    end

endmodule

// File: tb/tb_dcache_mem_responder.sv
// Scoreboard bench for dcache_mem_responder: access results and memory beats
// are predicted from a small cache/memory model and compared as the DUT produces them.
module tb_dcache_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        MemRead = 1'b0, MemWrite = 1'b0;
    logic [63:0] address = '0, writeData = '0;
    logic        hit, mem_req, mem_we, mem_ready = 1'b0;
    logic [63:0] readData, mem_addr, mem_wdata, mem_rdata = '0;

    dcache_mem_responder dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .address(address), .writeData(writeData), .hit(hit), .readData(readData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {logic we; logic [63:0] addr; logic [63:0] wdata;} memTxn_t;
    typedef struct {logic [63:0] data; int stall; logic chkData; string tag;} accExp_t;

    memTxn_t     memQ[$];
    accExp_t     accQ[$];
    logic [63:0] refMem[logic [63:0]];
    logic [63:0] bmem[logic [63:0]];
    logic        mValid[16];
    logic [54:0] mTag[16];
    int          readyDelay = 0;
    int          checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] defVal(input logic [63:0] a);
        return {32'hC0DE_0000, a[31:0]};
    endfunction

    function automatic logic [63:0] refRead(input logic [63:0] a);
        return refMem.exists(a) ? refMem[a] : defVal(a);
    endfunction

    // Backing memory: answers after readyDelay idle cycles per beat, checks every
    // requested cycle against the predicted transaction, retires it when a beat completes.
    always @(posedge clk or negedge rst_n) begin : responder
        static logic    pending = 1'b0;
        static int      waitCnt = 0;
        static memTxn_t t;
        if (!rst_n) begin
            mem_ready = 1'b0;
            pending   = 1'b0;
            waitCnt   = 0;
        end else begin
            #1;
            if (pending) begin
                pending = 1'b0;
                if (memQ.size() > 0) t = memQ.pop_front();
                if (t.we) bmem[t.addr] = t.wdata;
            end
            mem_ready = 1'b0;
            if (mem_req) begin
                if (memQ.size() == 0) begin
                    check("spurious_mem_req", {63'd0, mem_req}, 64'd0);
                end else begin
                    check("mem_we",   {63'd0, mem_we}, {63'd0, memQ[0].we});
                    check("mem_addr", mem_addr, memQ[0].addr);
                    if (memQ[0].we) check("mem_wdata", mem_wdata, memQ[0].wdata);
                end
                if (waitCnt >= readyDelay) begin
                    mem_ready = 1'b1;
                    waitCnt   = 0;
                    pending   = 1'b1;
                    mem_rdata = bmem.exists(mem_addr) ? bmem[mem_addr] : defVal(mem_addr);
                end else begin
                    waitCnt++;
                end
            end
        end
    end

    // One pipeline access: predict, drive, wait for hit, compare. Entered at posedge+2.
    task automatic access(input logic rd, input logic wr, input logic [63:0] a,
                          input logic [63:0] wd, input int dly, input string tag);
        accExp_t     e;
        int          stall;
        logic [3:0]  idx;
        logic [54:0] tg;
        logic [63:0] wa;
        idx = a[8:5];
        tg  = a[63:9];
        wa  = {a[63:3], 3'b000};
        e.tag = tag;
        e.chkData = 1'b0;
        e.data = '0;
        e.stall = 0;
        readyDelay = dly;
        if (wr) begin
            e.stall = 2 + dly;
            memQ.push_back('{1'b1, wa, wd});
            refMem[wa] = wd;
        end else if (rd) begin
            e.chkData = 1'b1;
            e.data = refRead(wa);
            if (!(mValid[idx] && mTag[idx] == tg)) begin
                e.stall = 1 + 4 * (dly + 1);
                for (int i = 0; i < 4; i++)
                    memQ.push_back('{1'b0, {a[63:5], 5'd0} + 64'(8 * i), 64'd0});
                mValid[idx] = 1'b1;
                mTag[idx]   = tg;
            end
        end
        accQ.push_back(e);
        MemRead   = rd;
        MemWrite  = wr;
        address   = a;
        writeData = wd;
        stall = 0;
        forever begin
            @(negedge clk);
            if (hit) break;
            stall++;
            if (stall > 200) begin
                check({tag, "_timeout_hit"}, {63'd0, hit}, 64'd1);
                break;
            end
        end
        e = accQ.pop_front();
        check({e.tag, "_stall"}, 64'(stall), 64'(e.stall));
        check({e.tag, "_req_idle"}, {63'd0, mem_req}, 64'd0);
        if (e.chkData) check({e.tag, "_rdata"}, readData, e.data);
        @(posedge clk);
        #2;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [63:0] addrs[6];
        addrs = '{64'h40, 64'h48, 64'h300, 64'h1000, 64'h1008, 64'h240};
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            refMem[64'h40 + 64'(8 * i)] = 64'h11 * 64'(i + 1);
            bmem[64'h40 + 64'(8 * i)]   = 64'h11 * 64'(i + 1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("rst_hit",       {63'd0, hit},     64'd1);
        check("rst_readData",  readData,         64'd0);
        check("rst_mem_req",   {63'd0, mem_req}, 64'd0);
        check("rst_mem_we",    {63'd0, mem_we},  64'd0);
        check("rst_mem_addr",  mem_addr,         64'd0);
        check("rst_mem_wdata", mem_wdata,        64'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #2;

        access(1'b1, 1'b0, 64'h40,   64'h0,    0, "t1_fill40");
        access(1'b1, 1'b0, 64'h50,   64'h0,    0, "t2_hit50");
        access(1'b0, 1'b1, 64'h48,   64'hDEAD, 3, "t3_wr48");
        access(1'b1, 1'b0, 64'h48,   64'h0,    0, "t3_rd48");
        access(1'b0, 1'b1, 64'h1000, 64'hBEEF, 0, "t4_wr1000");
        access(1'b1, 1'b0, 64'h1000, 64'h0,    1, "t4_rd1000");

        // Reset two beats into a fill of 0x300: the request must drop at once.
        readyDelay = 0;
        for (int i = 0; i < 4; i++) memQ.push_back('{1'b0, 64'h300 + 64'(8 * i), 64'd0});
        MemRead = 1'b1;
        address = 64'h300;
        repeat (3) @(posedge clk);
        #2;
        rst_n   = 1'b0;
        MemRead = 1'b0;
        #1;
        check("t5_rst_mem_req", {63'd0, mem_req}, 64'd0);
        check("t5_rst_hit",     {63'd0, hit},     64'd1);
        memQ.delete();
        for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #2;
        access(1'b1, 1'b0, 64'h40,  64'h0, 0, "t5_rd40");
        access(1'b1, 1'b0, 64'h300, 64'h0, 0, "t5_rd300");

        access(1'b1, 1'b1, 64'h80, 64'h5A5A_0080, 0, "t6_rdwr80");
        access(1'b1, 1'b0, 64'h80, 64'h0,         0, "t6_rd80");
        access(1'b0, 1'b0, 64'h80, 64'h0,         0, "idle");

        for (int n = 0; n < 12; n++) begin
            logic        wr;
            logic [63:0] a;
            wr = ($urandom_range(0, 2) == 0);
            a  = addrs[$urandom_range(0, 5)];
            access(~wr, wr, a, {$urandom, $urandom}, $urandom_range(0, 2), "rand");
        end

        check("memq_drained", 64'(memQ.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dcache_mem_responder.md
Name: dcache_mem_responder

Overview:
- Direct-mapped, write-through, no-write-allocate data cache that serves the MEM stage.
- Produces the `hit` stall/advance qualifier and `readData` consumed by the MEM/WB pipeline register.
- On a miss it runs a line-fill or write-through handshake with backing memory.
- `hit` is the responder side of the MEM/WB `hit` gate: 1 means the MEM/WB register may capture this cycle; 0 means the pipeline holds.

Parameters:
- LINES, 16, number of cache lines (power of 2).
- WORDS_PER_LINE, 4, 64-bit words per line (power of 2, ≥2).
- ADDR_W, 64, byte-address width.

Ports:
- clk  in  1  pipeline clock; all state updates on posedge.
- rst_n  in  1  asynchronous active-low reset.
- MemRead  in  1  load request from MEM stage.
- MemWrite  in  1  store request from MEM stage.
- address  in  ADDR_W  byte address (ALU result); bits [2:0] ignored.
- writeData  in  64  store data.
- hit  out  1  access complete or no access; MEM/WB may capture.
- readData  out  64  load data, valid when hit && MemRead.
- mem_req  out  1  backing-memory request.
- mem_we  out  1  1 = write, 0 = read; stable while mem_req.
- mem_addr  out  ADDR_W  word-aligned memory address; stable while mem_req.
- mem_wdata  out  64  write data; stable while mem_req.
- mem_ready  in  1  memory completes the current beat this cycle.
- mem_rdata  in  64  read data, valid with mem_ready.

Behaviour:
- Address split: offset [2:0]; word select next log2(WORDS_PER_LINE) bits; index next log2(LINES) bits; tag = remaining upper bits.
- Reset (async, rst_n=0):
  - all valid bits cleared; state = IDLE.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill counter=0.
  - hit=1, readData=0.
  - Tag/data arrays are not reset.
  - Reset mid-fill or mid-write abandons the memory transaction; mem_ready arriving after reset is ignored.
- States: IDLE, FILL, WRITE, WDONE.
- IDLE:
  - No request: hit=1.
  - MemRead, tag match and valid: hit=1 combinationally in the same cycle; readData = stored word. Must settle before negedge.
  - MemRead miss: hit=0; next posedge → FILL, counter=0, mem_req=1, mem_we=0, mem_addr = line base.
  - MemWrite (takes precedence if both requests are asserted): hit=0; next posedge → WRITE, mem_req=1, mem_we=1, mem_addr/mem_wdata latched.
- FILL:
  - hit=0.
  - On each mem_ready: store mem_rdata into word[counter]; counter++; mem_addr += 8.
  - Beat WORDS_PER_LINE-1 with mem_ready: write tag, set valid, mem_req=0 → IDLE.
  - The re-presented load then hits in IDLE; no extra memory access.
- WRITE:
  - hit=0; mem_req held until mem_ready.
  - On mem_ready: if tag matches a valid line, update that word in cache (no allocate on miss); mem_req=0 → WDONE.
- WDONE:
  - hit=1 for exactly one cycle; the request is ignored so the held store is not re-issued.
  - → IDLE.
- Handshake rules:
  - mem_req, mem_we, mem_addr and mem_wdata do not change while mem_req=1 && mem_ready=0.
  - mem_ready is ignored while mem_req=0.
  - mem_ready may be asserted in the first request cycle (zero wait states).
- Counter wraps only by leaving FILL. Line-base address has the word-select bits cleared.
- Latency:
  - read hit: 0 stall cycles.
  - read miss: 1 + sum of beat waits.
  - write: 1 + wait + 1 (WDONE).

Decomposition:
- Shared header/package holds:
  - state encodings (IDLE=0, FILL=1, WRITE=2, WDONE=3).
  - derived widths: OFF_W=3, WSEL_W, IDX_W, TAG_W.
  - macros for tag, index and word-select extraction.
- Natural sub-module `dcache_line_store`:
  - tag, valid and data arrays.
  - async clear of valid bits.
  - combinational read port; single posedge write port (word or tag+valid).

Test Plan:
1. Reset, then MemRead addr 0x40 with memory returning 0x11,0x22,0x33,0x44 and mem_ready every cycle → mem_addr 0x40,0x48,0x50,0x58; hit=0 for 5 cycles, then hit=1 with readData=0x11.
2. After test 1, MemRead 0x50 → hit=1 same cycle, readData=0x33, mem_req stays 0.
3. MemWrite 0x48 data 0xDEAD with mem_ready delayed 3 cycles → mem_req/addr/wdata stable for 4 cycles; hit=1 only in WDONE; then MemRead 0x48 hits with 0xDEAD.
4. MemWrite to uncached 0x1000 → memory write issued; subsequent MemRead 0x1000 misses and fills (no allocate).
5. Assert rst_n=0 mid-FILL after 2 beats → mem_req=0 immediately; MemRead 0x40 afterward misses (valid cleared).
6. MemRead and MemWrite both asserted on 0x80 → write path taken, mem_we=1.
